answer_checker: RTL
===================

// Module: answer_checker
// PURPOSE
//  Consumes the player's button-press stream and checks it against the round's generated pattern.
//  It is the receiving end of the pattern that pattern_generator writes and print_pattern displays.
//  It sits after input capture and is started by print_pattern_end.
//  It counts hits per round, applies the perfect-round bonus, accumulates the game score,
//  counts rounds and flags game over.
// PARAMETERS
//  ROUNDS         10       rounds per game; game_over after this many rounds complete
//  PERFECT_BONUS  2        score added on top of hits when every entry of a round is correct
//  TIMEOUT        1000000  idle clk cycles allowed in COLLECT before the round is force-closed
//  TO_W           24       width of the timeout counter; must hold TIMEOUT
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous, active-high reset
//  enable         in   1   1-cycle pulse: start a round (driven by print_pattern_end)
//  level          in   3   one-hot level: 001 = 4 entries, 010 = 8 entries, 100 = 16 entries
//  pattern        in   48  pattern entries; entry k = pattern[3k+2:3k], value 0..7 = button index-1
//  btn_valid      in   1   1-cycle pulse: one press accepted by input capture
//  btn_idx        in   3   pressed button, 0..7; qualified by btn_valid
//  busy           out  1   high in COLLECT
//  round_done     out  1   1-cycle pulse: round closed, round_* outputs and score valid
//  round_hits     out  5   correct entries in the last round, 0..16
//  round_perfect  out  1   last round: hits == length and no timeout
//  round_timeout  out  1   last round was closed by timeout
//  score          out  8   accumulated score, saturates at 255
//  round_count    out  4   completed rounds
//  game_over      out  1   high after ROUNDS rounds; held until rst
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, internal counters 0, asynchronously on rst=1.
//  FSM states: IDLE -> COLLECT -> FINISH -> (IDLE | OVER).
//  IDLE:
//   - enable=1 with a valid one-hot level: latch pattern and level, pos=0, hits=0, timer=0,
//     go to COLLECT.
//   - enable with level 000 or multi-hot is ignored; stay IDLE.
//   - btn_valid is ignored.
//  COLLECT:
//   - btn_valid: compare btn_idx with latched entry[pos]; hits += (equal); pos += 1; timer=0.
//   - Press at pos == len-1: go to FINISH on that edge; the last compare is included.
//   - Otherwise timer += 1 per cycle. At timer == TIMEOUT-1 with no press that cycle:
//     go to FINISH with timeout flag set; unentered positions count as misses.
//   - btn_valid and timeout in the same cycle: the press wins and the timer clears.
//   - enable is ignored.
//  Edge entering FINISH (all updates registered on this same edge):
//   - round_hits = hits; round_timeout = flag; round_perfect = (hits == len) & ~flag.
//   - score = min(255, score + hits + (round_perfect ? PERFECT_BONUS : 0)).
//   - round_count += 1.
//  FINISH (exactly 1 cycle):
//   - round_done = 1; inputs ignored.
//   - Next state is OVER if round_count == ROUNDS, else IDLE.
//  OVER:
//   - game_over = 1; all inputs ignored; score and round_* hold until rst.
//  Latency: round_done rises the cycle after the final accepted press.
//  Held values: round_* and score keep their values until the next FINISH.
//  busy: high exactly while in COLLECT.
//  Score arithmetic: 9-bit sum, clamped to 8 bits.
//  Length: len = 4, 8 or 16; pos is 5 bits; pattern entries >= len are never read.
//  Reset mid-round: returns to IDLE immediately; partial hits discarded; score and round_count cleared.
// TESTING
//  T1 reset: assert rst mid-COLLECT -> every output 0 next sample; a following enable starts a clean round.
//  T2 lvl 001, entries 0..3 = 5,2,7,0, presses 5,2,7,0:
//   -> round_done 1 cycle after the 4th press; hits=4, perfect=1, score=6, round_count=1.
//  T3 lvl 100, 16 presses with 3 wrong:
//   -> hits=13, perfect=0, score rises by 13; extra btn_valid after round_done is ignored.
//  T4 lvl 010, 3 correct presses, then idle with TIMEOUT=50:
//   -> round_done 50 cycles after the last press; hits=3, round_timeout=1; press on the final cycle defers timeout.
//  T5 10 perfect lvl-001 rounds:
//   -> score=60, round_count=10, game_over=1; a later enable leaves all outputs unchanged.
//  T6 invalid levels and saturation:
//   - enable with level 011 or 000 -> stays IDLE, busy=0.
//   - PERFECT_BONUS=200, two perfect lvl-001 rounds -> score 204 then 255 (saturated).

Source files
------------

// File: rtl/answer_checker.sv
// Compares the player's button presses with the latched round pattern, scores each round
// (hits plus perfect-round bonus, saturating), counts rounds and raises game_over.
module answer_checker #(
    parameter int ROUNDS        = 10,
    parameter int PERFECT_BONUS = 2,
    parameter int TIMEOUT       = 1000000,
    parameter int TO_W          = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [2:0]  level,
    input  logic [47:0] pattern,
    input  logic        btn_valid,
    input  logic [2:0]  btn_idx,
    output logic        busy,
    output logic        round_done,
    output logic [4:0]  round_hits,
    output logic        round_perfect,
    output logic        round_timeout,
    output logic [7:0]  score,
    output logic [3:0]  round_count,
    output logic        game_over
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FINISH  = 2'd2,
        OVER    = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [47:0]     pat_reg, pat_next;
    logic [4:0]      len_reg, len_next;
    logic [4:0]      pos_reg, pos_next;
    logic [4:0]      hits_reg, hits_next;
    logic [TO_W-1:0] timer_reg, timer_next;

    logic [4:0]      round_hits_reg, round_hits_next;
    logic            round_perfect_reg, round_perfect_next;
    logic            round_timeout_reg, round_timeout_next;
    logic [7:0]      score_reg, score_next;
    logic [3:0]      round_count_reg, round_count_next;

    logic [2:0]      entry [16];
    logic            level_ok;
    logic [4:0]      level_len;
    logic            hit;
    logic            finish;
    logic            flag;
    logic            perfect;
    logic [9:0]      sum;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_entry
            assign entry[gi] = pat_reg[3*gi +: 3];
        end
    endgenerate

    // Only a strictly one-hot level starts a round.
    always_comb begin
        level_ok  = 1'b1;
        level_len = 5'd4;
        case (level)
            3'b001:  level_len = 5'd4;
            3'b010:  level_len = 5'd8;
            3'b100:  level_len = 5'd16;
            default: level_ok  = 1'b0;
        endcase
    end

    assign hit = (btn_idx == entry[pos_reg[3:0]]);

    always_comb begin
        state_next         = state_reg;
        pat_next           = pat_reg;
        len_next           = len_reg;
        pos_next           = pos_reg;
        hits_next          = hits_reg;
        timer_next         = timer_reg;
        round_hits_next    = round_hits_reg;
        round_perfect_next = round_perfect_reg;
        round_timeout_next = round_timeout_reg;
        score_next         = score_reg;
        round_count_next   = round_count_reg;
        finish             = 1'b0;
        flag               = 1'b0;
        perfect            = 1'b0;
        sum                = 10'd0;

        case (state_reg)
            IDLE: begin
                if (enable && level_ok) begin
                    pat_next   = pattern;
                    len_next   = level_len;
                    pos_next   = 5'd0;
                    hits_next  = 5'd0;
                    timer_next = '0;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                // A press always beats a coincident timeout and restarts the idle timer.
                if (btn_valid) begin
                    hits_next  = hits_reg + {4'd0, hit};
                    pos_next   = pos_reg + 5'd1;
                    timer_next = '0;
                    finish     = (pos_reg == len_reg - 5'd1);
                end else if (timer_reg == TO_W'(TIMEOUT - 1)) begin
                    finish = 1'b1;
                    flag   = 1'b1;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end

                if (finish) begin
                    perfect            = (hits_next == len_reg) && !flag;
                    sum                = {2'd0, score_reg} + {5'd0, hits_next}
                                       + (perfect ? 10'(PERFECT_BONUS) : 10'd0);
                    score_next         = (sum > 10'd255) ? 8'd255 : sum[7:0];
                    round_hits_next    = hits_next;
                    round_perfect_next = perfect;
                    round_timeout_next = flag;
                    round_count_next   = round_count_reg + 4'd1;
                    state_next         = FINISH;
                end
            end
            FINISH: begin
                state_next = (round_count_reg == 4'(ROUNDS)) ? OVER : IDLE;
            end
            OVER: begin
                state_next = OVER;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            pat_reg           <= '0;
            len_reg           <= '0;
            pos_reg           <= '0;
            hits_reg          <= '0;
            timer_reg         <= '0;
            round_hits_reg    <= '0;
            round_perfect_reg <= 1'b0;
            round_timeout_reg <= 1'b0;
            score_reg         <= '0;
            round_count_reg   <= '0;
        end else begin
            state_reg         <= state_next;
            pat_reg           <= pat_next;
            len_reg           <= len_next;
            pos_reg           <= pos_next;
            hits_reg          <= hits_next;
            timer_reg         <= timer_next;
            round_hits_reg    <= round_hits_next;
            round_perfect_reg <= round_perfect_next;
            round_timeout_reg <= round_timeout_next;
            score_reg         <= score_next;
            round_count_reg   <= round_count_next;
        end
    end

    assign busy          = (state_reg == COLLECT);
    assign round_done    = (state_reg == FINISH);
    assign game_over     = (state_reg == OVER);
    assign round_hits    = round_hits_reg;
    assign round_perfect = round_perfect_reg;
    assign round_timeout = round_timeout_reg;
    assign score         = score_reg;
    assign round_count   = round_count_reg;

endmodule
